// File: rtl/lt_ctrl_pkg.sv
// lt_ctrl_pkg: shared latency-tester definitions used by the controller and the pattern generator.
package lt_ctrl_pkg;
    localparam logic [1:0] LT_POS_TOP_LEFT  = 2'd0;
    localparam logic [1:0] LT_POS_CENTER    = 2'd1;
    localparam logic [1:0] LT_POS_TOP_RIGHT = 2'd2;
    localparam logic [1:0] LT_POS_BOTTOM    = 2'd3;
    localparam int LT_WIDTH_DIV  = 4;
    localparam int LT_HEIGHT_DIV = 4;
endpackage

// File: rtl/lt_sensor_sync.sv
// lt_sensor_sync: two-flop synchronizer for asynchronous inputs, cleared to 0 on reset.
module lt_sensor_sync #(
    parameter int W = 1
) (
    input  logic         clk27,
    input  logic         reset_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    logic [W-1:0] r_meta;
    always_ff @(posedge clk27 or negedge reset_n)
        if (!reset_n) begin
            r_meta <= '0;
            o_q    <= '0;
        end else begin
            r_meta <= i_d;
            o_q    <= r_meta;
        end
endmodule

// File: rtl/lt_ctrl.sv
// lt_ctrl: drives the generator's latency box after a dark settle period and
// counts clk27 cycles until the photodiode sees light.
module lt_ctrl
    import lt_ctrl_pkg::*;
#(
    parameter int CNT_W         = 22,
    parameter int SETTLE_FRAMES = 4
) (
    input  logic             clk27,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       mode_sel,
    input  logic             vsync_in,
    input  logic             sensor_in,
    output logic             lt_active,
    output logic [1:0]       lt_mode,
    output logic             busy,
    output logic [CNT_W-1:0] result,
    output logic             result_valid,
    output logic             timeout,
    output logic             sensor_err
);
    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_MEASURE, S_DONE} state_t;
    state_t           r_state;
    logic             r_vs_prev;
    logic [3:0]       r_frames;
    logic [CNT_W-1:0] r_cnt;
    logic             w_sensor_s;
    logic             w_vs_fall;
    logic             w_last_frame;
    logic             w_cnt_max;

    lt_sensor_sync #(.W(1)) u_sync (
        .clk27  (clk27),
        .reset_n(reset_n),
        .i_d    (sensor_in),
        .o_q    (w_sensor_s)
    );

    assign w_vs_fall    = r_vs_prev & ~vsync_in;
    assign w_last_frame = r_frames == 4'(SETTLE_FRAMES - 1);
    assign w_cnt_max    = &r_cnt;

    always_ff @(posedge clk27 or negedge reset_n)
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_vs_prev    <= 1'b1;
            r_frames     <= '0;
            r_cnt        <= '0;
            lt_active    <= 1'b0;
            lt_mode      <= '0;
            busy         <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            timeout      <= 1'b0;
            sensor_err   <= 1'b0;
        end else begin
            r_vs_prev <= vsync_in;
            case (r_state)
                S_IDLE, S_DONE:
                    if (start) begin
                        lt_mode      <= mode_sel;
                        result_valid <= 1'b0;
                        timeout      <= 1'b0;
                        sensor_err   <= 1'b0;
                        r_frames     <= '0;
                        busy         <= 1'b1;
                        r_state      <= S_SETTLE;
                    end
                S_SETTLE:
                    if (w_vs_fall) begin
                        if (!w_last_frame)
                            r_frames <= r_frames + 4'd1;
                        else if (w_sensor_s) begin
                            sensor_err <= 1'b1;
                            busy       <= 1'b0;
                            r_state    <= S_DONE;
                        end else begin
                            lt_active <= 1'b1;
                            r_cnt     <= '0;
                            r_state   <= S_MEASURE;
                        end
                    end
                S_MEASURE:
                    // the sensor takes priority over a simultaneous full-scale count
                    if (w_sensor_s || w_cnt_max) begin
                        result       <= r_cnt;
                        result_valid <= w_sensor_s;
                        timeout      <= ~w_sensor_s;
                        lt_active    <= 1'b0;
                        busy         <= 1'b0;
                        r_state      <= S_DONE;
                    end else
                        r_cnt <= r_cnt + CNT_W'(1);
                default: r_state <= S_IDLE;
            endcase
        end
endmodule

// File: tb/tb_lt_ctrl.sv
// tb_lt_ctrl: directed runs on a 22-bit and an 8-bit controller; a busy-falling
// monitor checks each finished run against a queue of expected outcomes.
module tb_lt_ctrl;
    import lt_ctrl_pkg::*;

    typedef struct {
        logic [21:0] res;
        logic [2:0]  fl;
        logic [1:0]  md;
    } exp_t;

    logic clk = 1'b0, rst_n = 1'b0, vsync = 1'b1;
    logic st_a = 1'b0, sn_a = 1'b0, st_b = 1'b0, sn_b = 1'b0;
    logic [1:0] ms_a = '0, ms_b = '0;
    logic la_a, busy_a, rv_a, to_a, se_a, la_b, busy_b, rv_b, to_b, se_b;
    logic [1:0] lm_a, lm_b;
    logic [21:0] res_a;
    logic [7:0] res_b;
    int total = 0, bad = 0, cyc = 0, nfall = 0, base = 0;
    exp_t q_a[$], q_b[$];
    exp_t ea, eb;
    bit pb_a = 0, pb_b = 0;

    lt_ctrl dut_a (
        .clk27(clk), .reset_n(rst_n), .start(st_a), .mode_sel(ms_a), .vsync_in(vsync),
        .sensor_in(sn_a), .lt_active(la_a), .lt_mode(lm_a), .busy(busy_a), .result(res_a),
        .result_valid(rv_a), .timeout(to_a), .sensor_err(se_a)
    );

    lt_ctrl #(.CNT_W(8)) dut_b (
        .clk27(clk), .reset_n(rst_n), .start(st_b), .mode_sel(ms_b), .vsync_in(vsync),
        .sensor_in(sn_b), .lt_active(la_b), .lt_mode(lm_b), .busy(busy_b), .result(res_b),
        .result_valid(rv_b), .timeout(to_b), .sensor_err(se_b)
    );

    always #5 clk = ~clk;

    // 40-cycle frames with a 4-cycle low VSYNC, changed away from both clock edges
    initial forever begin
        @(posedge clk);
        #2;
        cyc++;
        if (vsync && (cyc % 40) < 4) nfall++;
        vsync = (cyc % 40) >= 4;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && pb_a && !busy_a) begin
            if (q_a.size() == 0) chk("a_unexpected_done", 1, 0);
            else begin
                ea = q_a.pop_front();
                chk("a_flags", {rv_a, to_a, se_a}, ea.fl);
                chk("a_mode", lm_a, ea.md);
                chk("a_la_off", la_a, 0);
                if (ea.fl[2] | ea.fl[1]) chk("a_result", res_a, ea.res);
            end
        end
        if (rst_n && pb_b && !busy_b) begin
            if (q_b.size() == 0) chk("b_unexpected_done", 1, 0);
            else begin
                eb = q_b.pop_front();
                chk("b_flags", {rv_b, to_b, se_b}, eb.fl);
                chk("b_mode", lm_b, eb.md);
                chk("b_la_off", la_b, 0);
                if (eb.fl[2] | eb.fl[1]) chk("b_result", res_b, eb.res);
            end
        end
        pb_a = busy_a;
        pb_b = busy_b;
    end

    task automatic start_a(input logic [1:0] m);
        @(negedge clk);
        ms_a = m; st_a = 1'b1; base = nfall;
        @(negedge clk);
        st_a = 1'b0;
        chk("a_busy_start", busy_a, 1);
        chk("a_mode_start", lm_a, m);
        chk("a_flags_clear", {rv_a, to_a, se_a}, 0);
    endtask

    task automatic start_b(input logic [1:0] m);
        @(negedge clk);
        ms_b = m; st_b = 1'b1; base = nfall;
        @(negedge clk);
        st_b = 1'b0;
        chk("b_busy_start", busy_b, 1);
        chk("b_mode_start", lm_b, m);
        chk("b_flags_clear", {rv_b, to_b, se_b}, 0);
    endtask

    task automatic wait_la(input bit b);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (b ? la_b : la_a) break;
        end
        chk(b ? "b_la_rise" : "a_la_rise", b ? la_b : la_a, 1);
        chk(b ? "b_frames" : "a_frames", nfall - base, 4);
    endtask

    task automatic wait_idle(input bit b);
        for (int i = 0; i < 400 && (b ? busy_b : busy_a); i++) @(negedge clk);
        chk(b ? "b_finished" : "a_finished", b ? busy_b : busy_a, 0);
    endtask

    task automatic run_a(input logic [1:0] m, input int k, input bit ign);
        start_a(m);
        if (ign) begin
            repeat (3) @(negedge clk);
            ms_a = ~m; st_a = 1'b1;
            @(negedge clk);
            st_a = 1'b0;
            chk("a_ign_settle_mode", lm_a, m);
            chk("a_ign_settle_busy", busy_a, 1);
        end
        wait_la(0);
        q_a.push_back('{res: 22'(k + 2), fl: 3'b100, md: m});
        if (ign) begin
            st_a = 1'b1;
            @(negedge clk);
            st_a = 1'b0;
            repeat (k - 1) @(negedge clk);
            chk("a_ign_measure_la", la_a, 1);
        end else
            repeat (k) @(negedge clk);
        sn_a = 1'b1;
        wait_idle(0);
        sn_a = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got hang want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        int n;
        repeat (3) @(negedge clk);
        chk("rst_outputs_a", {la_a, lm_a, busy_a, rv_a, to_a, se_a}, 0);
        chk("rst_result_a", res_a, 0);
        chk("rst_outputs_b", {la_b, lm_b, busy_b, rv_b, to_b, se_b, res_b}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_a(LT_POS_CENTER, 1000, 0);
        run_a(LT_POS_TOP_RIGHT, 100, 1);

        sn_a = 1'b1;
        repeat (3) @(negedge clk);
        start_a(LT_POS_BOTTOM);
        q_a.push_back('{res: '0, fl: 3'b001, md: LT_POS_BOTTOM});
        seen = 0;
        for (int i = 0; i < 300 && busy_a; i++) begin
            @(negedge clk);
            seen |= la_a;
        end
        chk("a_stuck_la_never", seen, 0);
        sn_a = 1'b0;
        repeat (3) @(negedge clk);
        run_a(LT_POS_TOP_LEFT, 20, 0);

        start_b(LT_POS_CENTER);
        wait_la(1);
        q_b.push_back('{res: 22'd255, fl: 3'b010, md: LT_POS_CENTER});
        n = 1;
        for (int i = 0; i < 400 && busy_b; i++) begin
            @(negedge clk);
            if (la_b) n++;
        end
        chk("b_timeout_cycles", n, 256);
        repeat (3) @(negedge clk);

        start_b(LT_POS_BOTTOM);
        wait_la(1);
        q_b.push_back('{res: 22'd255, fl: 3'b100, md: LT_POS_BOTTOM});
        repeat (253) @(negedge clk);
        sn_b = 1'b1;
        wait_idle(1);
        sn_b = 1'b0;
        repeat (3) @(negedge clk);

        start_a(LT_POS_BOTTOM);
        wait_la(0);
        repeat (20) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_la", la_a, 0);
        chk("rst_mid_busy", busy_a, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mid_state", {la_a, lm_a, busy_a, rv_a, to_a, se_a}, 0);
        chk("rst_mid_result", res_a, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_a(LT_POS_CENTER, 10, 0);

        chk("a_queue_empty", q_a.size(), 0);
        chk("b_queue_empty", q_b.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/lt_ctrl.md
# lt_ctrl

Latency-tester controller that sits directly upstream of the video pattern generator and drives its `lt_active`/`lt_mode` inputs. On a start request it holds the test pattern dark for a settle period and then lights the selected box at a frame boundary. It then counts clk27 cycles until an external photodiode reports light, and reports the count as the measured display latency, or flags a timeout or stuck sensor.

## Interface
- CNT_W, 22: latency counter width; full scale is 2^22−1 cycles, about 155 ms.
- SETTLE_FRAMES, 4: dark frames shown before the box is lit, range 1–15.
- clk27  in  1  pixel clock, 27 MHz.
- reset_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle request, synchronous to clk27.
- mode_sel  in  2  box position (LT_POS_*), sampled when `start` is accepted.
- vsync_in  in  1  generator VSYNC, registered, synchronous to clk27, active low.
- sensor_in  in  1  photodiode comparator, asynchronous, high means light.
- lt_active  out  1  to generator; 1 selects the box pattern.
- lt_mode  out  2  to generator; box position.
- busy  out  1  measurement in progress.
- result  out  CNT_W  measured cycles.
- result_valid  out  1  `result` holds a valid measurement.
- timeout  out  1  no light detected before the counter reached full scale.
- sensor_err  out  1  sensor was already high at the end of the settle period.

## Operation
- `sensor_in` passes through a 2-flop synchronizer; its output is `sensor_s`.
- Frame tick `vs_fall` = previous `vsync_in` AND NOT current `vsync_in`.
- States:
  - IDLE: reset state.
  - SETTLE: `lt_active` = 0, counting `vs_fall` ticks.
  - MEASURE: `lt_active` = 1, counter running.
  - DONE: outputs held.
- IDLE/DONE + `start`: latch `mode_sel` into `lt_mode`; clear `result_valid`, `timeout`, `sensor_err` and the frame counter; go to SETTLE.
- `start` in SETTLE or MEASURE is ignored.
- SETTLE, on the SETTLE_FRAMES-th `vs_fall`:
  - If `sensor_s` = 1: set `sensor_err`, go to DONE; `lt_active` stays 0.
  - Otherwise: set `lt_active` = 1, clear the counter, go to MEASURE.
- MEASURE: the counter increments every cycle.
  - If `sensor_s` = 1: `result` takes the counter value, `result_valid` = 1, `lt_active` = 0, go to DONE.
  - If the counter is all-ones and `sensor_s` = 0: `result` = all-ones, `timeout` = 1, `lt_active` = 0, go to DONE.
  - If `sensor_s` = 1 and the counter is all-ones in the same cycle, the sensor wins: `result_valid` = 1, `result` = all-ones, `timeout` = 0.
- DONE holds `result`, its flags and `lt_mode` until the next accepted `start`.
- `busy` = 1 in SETTLE and MEASURE only.
- The counter saturates at all-ones and never wraps.

## Timing
- Reset values: `lt_active` = 0, `lt_mode` = 0, `busy` = 0, `result` = 0, `result_valid` = 0, `timeout` = 0, `sensor_err` = 0, frame counter = 0, synchronizer = 0, previous-vsync register = 1.
- Reset asserted mid-measurement returns everything to the reset values immediately, including dropping `lt_active`.
- `start` accepted at edge t: `busy` = 1 and `lt_mode` updated after edge t.
- `lt_active` rises on the edge that samples the final `vs_fall`. In that first cycle the counter reads 0.
- The synchronizer is not compensated. A `sensor_in` rise set up k cycles after `lt_active` rises yields `result` = k+2.
- `result`, `result_valid` and the falling edge of `lt_active` update on the same edge.
- All outputs are registered; there are no combinational paths from input to output.

## Structure
- The LT_POS_* codes live in the shared include/package, beside LT_WIDTH_DIV and LT_HEIGHT_DIV. The state encoding is local to this block.
- Sub-module `lt_sensor_sync`: 2-flop synchronizer with parameterized width and reset value 0.
- Target size is 150–250 lines of RTL.

## Test plan
- Normal run: SETTLE_FRAMES = 4, `mode_sel` = CENTER, `sensor_in` rises 1000 cycles after `lt_active` rises.
  - Expect `lt_active` to rise at the 4th `vs_fall` after start.
  - Expect `result` = 1002, `result_valid` = 1, `lt_active` = 0 afterwards, `lt_mode` = CENTER.
- Stuck sensor: `sensor_in` = 1 throughout. Expect `sensor_err` = 1, `result_valid` = 0, `lt_active` never 1.
- Timeout: CNT_W = 8, sensor stays low. Expect `result` = 255, `timeout` = 1, `lt_active` = 0 after 256 MEASURE cycles.
- Simultaneous: CNT_W = 8, `sensor_s` first high in the cycle the counter reads 255. Expect `result_valid` = 1, `result` = 255, `timeout` = 0.
- Ignore and restart:
  - `start` pulses during SETTLE and MEASURE have no effect.
  - A `start` in DONE clears all three flags on the next edge and re-runs the test with the new `mode_sel`.
- Reset mid-MEASURE: `reset_n` low for 3 cycles. Expect `lt_active` = 0 and `busy` = 0 at once; a subsequent run completes normally.
